// File: rtl/ring_buf_pkg.sv
// Shared constants, entry layout and index helpers for the out-of-order ring buffer.
// Used by ring_buf_ooo and ring_buf_retire_sel.
package ring_buf_pkg;

  localparam int DATA_DEF  = 64;
  localparam int DEPTH_DEF = 16;
  localparam int WRITE_DEF = 4;
  localparam int READ_DEF  = 4;
  localparam int CMPL_DEF  = 2;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic [DATA_DEF-1:0] data;
  } entry_t;

  // Callers guarantee a, b < depth, so a single conditional subtract is enough.
  function automatic int ring_add(input int a, input int b, input int depth);
    int s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction

  function automatic int cnt_bits(input logic [31:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ring_buf_retire_sel.sv
// Retire-side view of the ring: per-lane index/data, prefix valid vector and retire count.
// RING_BUF_OOO_BYPASS_EN forwards same-cycle completions straight onto the retire lanes.
module ring_buf_retire_sel
  import ring_buf_pkg::*;
#(
  parameter int DATA  = DATA_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int READ  = READ_DEF,
  parameter int CMPL  = CMPL_DEF,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic [ADDR-1:0]             tail_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0]            done_i,
  input  logic [DEPTH-1:0][DATA-1:0]  data_i,
  input  logic [CMPL-1:0]             cv_i,
  input  logic [CMPL-1:0][ADDR-1:0]   cidx_i,
  input  logic [CMPL-1:0][DATA-1:0]   cd_i,
  input  logic [READ-1:0]             re_i,
  output logic [READ-1:0][DATA-1:0]   rd_o,
  output logic [READ-1:0][ADDR-1:0]   ridx_o,
  output logic [READ-1:0]             rv_o,
  output int                          rnum_o
);

  logic [READ-1:0] take;

`ifndef RING_BUF_OOO_BYPASS_EN
  logic unused_cmpl;
  assign unused_cmpl = ^{cv_i, cidx_i, cd_i};
`endif

  always_comb begin
    logic            run;
    logic            tk;
    logic            seen;
    logic [ADDR-1:0] ix;
    logic [DATA-1:0] dat;
    rd_o   = '0;
    ridx_o = '0;
    rv_o   = '0;
    take   = '0;
    run    = 1'b1;
    tk     = 1'b1;
    seen   = 1'b0;
    ix     = '0;
    dat    = '0;
    for (int i = 0; i < READ; i++) begin
      ix   = ADDR'(ring_add(int'(tail_i), i, DEPTH));
      seen = done_i[ix];
      dat  = data_i[ix];
`ifdef RING_BUF_OOO_BYPASS_EN
      // Later lanes override earlier ones, matching the registered completion priority.
      for (int k = 0; k < CMPL; k++) begin
        if (cv_i[k] && (cidx_i[k] == ix) && valid_i[ix]) begin
          seen = 1'b1;
          dat  = cd_i[k];
        end
      end
`endif
      run       = run & valid_i[ix] & seen;
      rv_o[i]   = run;
      rd_o[i]   = dat;
      ridx_o[i] = ix;
      tk        = tk & re_i[i] & run;
      take[i]   = tk;
    end
    rnum_o = cnt_bits(32'(take), READ);
  end

endmodule

// File: rtl/ring_buf_ooo.sv
// Circular buffer: in-order allocate, out-of-order completion by index, in-order retire.
// Optional RING_BUF_OOO_BYPASS_EN enables zero-cycle complete-to-retire forwarding.
module ring_buf_ooo
  import ring_buf_pkg::*;
#(
  parameter int DATA  = DATA_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int WRITE = WRITE_DEF,
  parameter int READ  = READ_DEF,
  parameter int CMPL  = CMPL_DEF,
  localparam int ADDR = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_,
  input  logic [WRITE-1:0]          we,
  input  logic [WRITE-1:0][DATA-1:0] wd,
  output logic [WRITE-1:0][ADDR-1:0] widx,
  output logic                      busy,
  input  logic [CMPL-1:0]           cv,
  input  logic [CMPL-1:0][ADDR-1:0] cidx,
  input  logic [CMPL-1:0][DATA-1:0] cd,
  input  logic [READ-1:0]           re,
  output logic [READ-1:0][DATA-1:0] rd,
  output logic [READ-1:0][ADDR-1:0] ridx,
  output logic [READ-1:0]           rv,
  output logic [ADDR:0]             count
);

  logic [ADDR-1:0]            head_q, head_d;
  logic [ADDR-1:0]            tail_q, tail_d;
  logic [ADDR:0]              count_q, count_d;
  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0]           done_q, done_d;
  logic [DEPTH-1:0][DATA-1:0] data_q, data_d;

  int   free;
  int   wnum_req;
  int   wnum;
  int   rnum;
  logic alloc_ok;

  ring_buf_retire_sel #(
    .DATA (DATA),
    .DEPTH(DEPTH),
    .READ (READ),
    .CMPL (CMPL),
    .ADDR (ADDR)
  ) u_retire_sel (
    .tail_i (tail_q),
    .valid_i(valid_q),
    .done_i (done_q),
    .data_i (data_q),
    .cv_i   (cv),
    .cidx_i (cidx),
    .cd_i   (cd),
    .re_i   (re),
    .rd_o   (rd),
    .ridx_o (ridx),
    .rv_o   (rv),
    .rnum_o (rnum)
  );

  // Space is judged on the registered count, so slots freed this cycle are not reused yet.
  assign free     = DEPTH - int'(count_q);
  assign busy     = (free < WRITE);
  assign wnum_req = cnt_bits(32'(we), WRITE);
  assign alloc_ok = (wnum_req <= free);
  assign wnum     = alloc_ok ? wnum_req : 0;
  assign count    = count_q;

  always_comb begin
    int off;
    off  = 0;
    widx = '0;
    for (int i = 0; i < WRITE; i++) begin
      widx[i] = ADDR'(ring_add(int'(head_q), off, DEPTH));
      if (we[i]) off++;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    data_d  = data_q;

    for (int k = 0; k < CMPL; k++) begin
      if (cv[k] && (int'(cidx[k]) < DEPTH) && valid_q[cidx[k]]) begin
        done_d[cidx[k]] = 1'b1;
        data_d[cidx[k]] = cd[k];
      end
    end

    for (int i = 0; i < READ; i++) begin
      if (i < rnum) begin
        valid_d[ridx[i]] = 1'b0;
        done_d[ridx[i]]  = 1'b0;
        data_d[ridx[i]]  = '0;
      end
    end

    // Allocation targets are free before the edge, so they never collide with the above.
    if (alloc_ok) begin
      for (int i = 0; i < WRITE; i++) begin
        if (we[i]) begin
          valid_d[widx[i]] = 1'b1;
          done_d[widx[i]]  = 1'b0;
          data_d[widx[i]]  = wd[i];
        end
      end
    end

    head_d  = ADDR'(ring_add(int'(head_q), wnum, DEPTH));
    tail_d  = ADDR'(ring_add(int'(tail_q), rnum, DEPTH));
    count_d = (ADDR+1)'(int'(count_q) + wnum - rnum);

    if (!flush_) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_ring_buf_ooo.sv
// Directed bench for ring_buf_ooo at default parameters; follows RING_BUF_OOO_BYPASS_EN
// for the complete-to-retire check.
module tb_ring_buf_ooo;

  logic             clk;
  logic             reset;
  logic             flush_;
  logic [3:0]       we;
  logic [3:0][63:0] wd;
  logic [3:0][3:0]  widx;
  logic             busy;
  logic [1:0]       cv;
  logic [1:0][3:0]  cidx;
  logic [1:0][63:0] cd;
  logic [3:0]       re;
  logic [3:0][63:0] rd;
  logic [3:0][3:0]  ridx;
  logic [3:0]       rv;
  logic [4:0]       count;

  int n_vec = 0;
  int n_err = 0;

  ring_buf_ooo dut (
    .clk   (clk),
    .reset (reset),
    .flush_(flush_),
    .we    (we),
    .wd    (wd),
    .widx  (widx),
    .busy  (busy),
    .cv    (cv),
    .cidx  (cidx),
    .cd    (cd),
    .re    (re),
    .rd    (rd),
    .ridx  (ridx),
    .rv    (rv),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush_ = 1'b1; we = '0; wd = '0; cv = '0; cidx = '0; cd = '0; re = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rv",    64'(rv),    64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    we = 4'b1111;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_widx%0d", i), 64'(widx[i]), 64'(i));
    we = '0;
    reset = 1'b0;
    tick();

    // allocate four, then complete out of order
    we = 4'b1111;
    for (int i = 0; i < 4; i++) wd[i] = 64'h100 + 64'(i);
    tick();
    we = '0;
    #1;
    chk("alloc4_count", 64'(count), 64'd4);
    chk("alloc4_rv",    64'(rv),    64'd0);

    cv = 2'b01; cidx[0] = 4'd2; cd[0] = 64'hA2;
    tick();
    cv = '0;
    #1;
    chk("cmpl2_rv", 64'(rv), 64'd0);

    cv = 2'b11; cidx[0] = 4'd0; cd[0] = 64'hA0; cidx[1] = 4'd1; cd[1] = 64'hA1;
    tick();
    cv = '0;
    #1;
    chk("cmpl01_rv", 64'(rv),    64'b0111);
    chk("rd0",       64'(rd[0]), 64'hA0);
    chk("rd2",       64'(rd[2]), 64'hA2);
    chk("rd3_init",  64'(rd[3]), 64'h103);

    re = 4'b1111;
    tick();
    re = '0;
    #1;
    chk("ret3_count", 64'(count),   64'd1);
    chk("ret3_ridx0", 64'(ridx[0]), 64'd3);
    chk("ret3_rv",    64'(rv),      64'd0);

    // sparse allocate lanes
    we = 4'b0001; wd[0] = 64'h204;
    tick();
    we = '0;
    #1;
    chk("alloc1_count", 64'(count), 64'd2);
    we = 4'b1010; wd[1] = 64'h205; wd[3] = 64'h206;
    #1;
    chk("sparse_widx1", 64'(widx[1]), 64'd5);
    chk("sparse_widx3", 64'(widx[3]), 64'd6);
    tick();
    we = '0;
    #1;
    chk("sparse_count", 64'(count), 64'd4);

    // completion to an empty slot, then two lanes on one index
    cv = 2'b01; cidx[0] = 4'd9; cd[0] = 64'hDEAD;
    tick();
    cv = '0;
    #1;
    chk("cv_empty_count", 64'(count), 64'd4);
    chk("cv_empty_rv",    64'(rv),    64'd0);

    cv = 2'b11; cidx[0] = 4'd3; cd[0] = 64'hB0; cidx[1] = 4'd3; cd[1] = 64'hB1;
    tick();
    cv = '0;
    #1;
    chk("dup_rv",  64'(rv),    64'b0001);
    chk("dup_rd0", 64'(rd[0]), 64'hB1);

    // retire and complete in the same cycle on different entries
    re = 4'b0001; cv = 2'b01; cidx[0] = 4'd4; cd[0] = 64'hC4;
    tick();
    re = '0; cv = '0;
    #1;
    chk("mix_count", 64'(count),   64'd3);
    chk("mix_ridx0", 64'(ridx[0]), 64'd4);
    chk("mix_rv",    64'(rv),      64'b0001);
    chk("mix_rd0",   64'(rd[0]),   64'hC4);

    // gap at idx5 stops retirement after one lane
    cv = 2'b01; cidx[0] = 4'd6; cd[0] = 64'hC6;
    tick();
    cv = '0;
    #1;
    chk("gap_rv", 64'(rv), 64'b0001);
    re = 4'b1111;
    tick();
    re = '0;
    #1;
    chk("gap_count", 64'(count),   64'd2);
    chk("gap_ridx0", 64'(ridx[0]), 64'd5);
    chk("gap_rv2",   64'(rv),      64'd0);

    // fill with head wrapping 14 -> 1
    we = 4'b1111;
    tick();
    we = 4'b0111;
    tick();
    #1;
    chk("fill_count9", 64'(count), 64'd9);
    chk("wrap_widx0",  64'(widx[0]), 64'd14);
    chk("wrap_widx1",  64'(widx[1]), 64'd15);
    chk("wrap_widx2",  64'(widx[2]), 64'd0);
    tick();
    we = '0;
    #1;
    chk("fill_count12", 64'(count), 64'd12);
    chk("fill_busy12",  64'(busy),  64'd0);
    we = 4'b0001;
    #1;
    chk("fill_widx1", 64'(widx[0]), 64'd1);
    tick();
    we = '0;
    #1;
    chk("fill_count13", 64'(count), 64'd13);
    chk("fill_busy13",  64'(busy),  64'd1);
    we = 4'b1111;
    tick();
    #1;
    chk("over_count", 64'(count),   64'd13);
    chk("over_widx0", 64'(widx[0]), 64'd2);
    we = 4'b0111;
    tick();
    we = '0;
    #1;
    chk("full_count", 64'(count),   64'd16);
    chk("full_busy",  64'(busy),    64'd1);
    chk("full_rv",    64'(rv),      64'd0);
    chk("full_ridx0", 64'(ridx[0]), 64'd5);

    cv = 2'b01; cidx[0] = 4'd5; cd[0] = 64'hD5;
    tick();
    cv = '0;
    #1;
    chk("full_rv2",  64'(rv),    64'b0011);
    chk("full_rd0",  64'(rd[0]), 64'hD5);
    chk("full_rd1",  64'(rd[1]), 64'hC6);
    re = 4'b0011;
    tick();
    re = '0;
    #1;
    chk("full_ret_count", 64'(count),   64'd14);
    chk("full_ret_ridx0", 64'(ridx[0]), 64'd7);

    // flush overrides every strobe
    flush_ = 1'b0; we = 4'b1111; cv = 2'b11; cidx[0] = 4'd7; cidx[1] = 4'd8; re = 4'b1111;
    tick();
    flush_ = 1'b1; cv = '0; re = '0;
    #1;
    chk("flush_count", 64'(count),   64'd0);
    chk("flush_rv",    64'(rv),      64'd0);
    chk("flush_widx0", 64'(widx[0]), 64'd0);
    chk("flush_ridx0", 64'(ridx[0]), 64'd0);
    we = '0;

    // complete and retire in the same cycle on the tail entry
    we = 4'b0001; wd[0] = 64'h55;
    tick();
    we = '0;
    #1;
    chk("byp_alloc_count", 64'(count), 64'd1);
    cv = 2'b01; cidx[0] = 4'd0; cd[0] = 64'hEE; re = 4'b0001;
    #1;
`ifdef RING_BUF_OOO_BYPASS_EN
    chk("byp_rv",  64'(rv),    64'b0001);
    chk("byp_rd0", 64'(rd[0]), 64'hEE);
    tick();
    cv = '0; re = '0;
    #1;
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_rv",  64'(rv),    64'd0);
    chk("nobyp_rd0", 64'(rd[0]), 64'h55);
    tick();
    cv = '0; re = '0;
    #1;
    chk("nobyp_count", 64'(count), 64'd1);
    chk("nobyp_rv2",   64'(rv),    64'b0001);
    chk("nobyp_rd0b",  64'(rd[0]), 64'hEE);
    re = 4'b0001;
    tick();
    re = '0;
    #1;
    chk("nobyp_ret_count", 64'(count), 64'd0);
`endif

    // asynchronous reset between edges
    we = 4'b0011;
    tick();
    we = '0;
    #1;
    chk("pre_async_count", 64'(count), 64'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("async_count", 64'(count),   64'd0);
    chk("async_ridx0", 64'(ridx[0]), 64'd0);
    reset = 1'b0;
    tick();
    #1;
    chk("post_async_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
